instruction_encoder: RTL

- Inverse of the instruction decoder. Accepts one instruction as separate fields over a valid/ready handshake, packs it into a 16-bit Simple RISC Machine word, and writes it into instruction RAM at an auto-incrementing address.
- Used as the program loader and test-stimulus generator in front of the CPU's instruction memory.
- Checks that each immediate fits the field width the decoder will sign-extend from. A value that does not fit is reported as an error, never truncated.

---
 rtl/srm_isa_pkg.sv | 45 ++++
 rtl/instr_field_pack.sv | 45 ++++
 rtl/instruction_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/srm_isa_pkg.sv
// Shared Simple RISC Machine ISA definitions: opcodes, operand formats,
// instruction field positions and the loader state encoding.
package srm_isa_pkg;

    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_BL   = 3'b010;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [1:0] {
        FMT_REG  = 2'b00,
        FMT_IMM8 = 2'b01,
        FMT_IMM5 = 2'b10,
        FMT_NONE = 2'b11
    } fmt_e;

    localparam int OPCODE_LSB = 13;
    localparam int OP_LSB     = 11;
    localparam int RN_LSB     = 8;
    localparam int RD_LSB     = 5;
    localparam int SHIFT_LSB  = 3;
    localparam int RM_LSB     = 0;

    typedef enum logic [1:0] {
        S_READY = 2'b00,
        S_WRITE = 2'b01,
        S_FULL  = 2'b10,
        S_ERR   = 2'b11
    } state_e;

    // True when imm sign-extends cleanly from a field of 'width' bits,
    // i.e. bits [15:width-1] all equal the sign bit.
    function automatic logic imm_fits(input logic [15:0] imm, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i >= width - 1 && imm[i] != imm[15]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: assembles one 16-bit instruction word from its
// fields and flags immediates that would not survive sign extension.
module instr_field_pack
    import srm_isa_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    input  logic [1:0]  fmt,
    input  logic [2:0]  rn,
    input  logic [2:0]  rd,
    input  logic [2:0]  rm,
    input  logic [1:0]  shift,
    input  logic [15:0] imm,
    output logic [15:0] word,
    output logic        range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        word[OPCODE_LSB +: 3] = opcode;
        word[OP_LSB +: 2]     = op;
        case (fmt)
            FMT_REG: begin
                word[RN_LSB +: 3]    = rn;
                word[RD_LSB +: 3]    = rd;
                word[SHIFT_LSB +: 2] = shift;
                word[RM_LSB +: 3]    = rm;
            end
            FMT_IMM8: begin
                word[RN_LSB +: 3] = rn;
                word[7:0]         = imm[7:0];
                range_err         = ~imm_fits(imm, 8);
            end
            FMT_IMM5: begin
                word[RN_LSB +: 3] = rn;
                word[RD_LSB +: 3] = rd;
                word[4:0]         = imm[4:0];
                range_err         = ~imm_fits(imm, 5);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: accepts instruction fields, packs them into SRM words and
// writes them to instruction RAM at consecutive addresses from BASE_ADDR.
module instruction_encoder
    import srm_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_fmt,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rm,
    input  logic [1:0]        in_shift,
    input  logic [15:0]       in_imm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_write,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [15:0]       packed_word;
    logic              range_err;

    instr_field_pack u_pack (
        .opcode    (in_opcode),
        .op        (in_op),
        .fmt       (in_fmt),
        .rn        (in_rn),
        .rd        (in_rd),
        .rm        (in_rm),
        .shift     (in_shift),
        .imm       (in_imm),
        .word      (packed_word),
        .range_err (range_err)
    );

    // Handshake: a transfer happens on a rising edge where in_valid and
    // in_ready are both high; in_* only need to be stable in that cycle.
    // clear suppresses in_ready so a simultaneous input is never taken.
    assign in_ready = (state_q == S_READY) & ~clear;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        if (clear) begin
            state_d = S_READY;
            addr_d  = FIRST_ADDR;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (in_valid) begin
                        if (range_err) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            wdata_d = packed_word;
                            state_d = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    count_d = count_q + 1'b1;
                    // Stopping at the last address is what keeps mem_addr from wrapping.
                    if (addr_q == LAST_ADDR) begin
                        full_d  = 1'b1;
                        state_d = S_FULL;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_READY;
            addr_q  <= FIRST_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign mem_write  = (state_q == S_WRITE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule
